lpc_frame_reader: RTL

- Sequences port 2 of the 2048x16 dual-port sample RAM; the host fills frames through port 1.
- Treats the RAM as two ping-pong banks of FRAME_LEN words each.
- On a start command for a bank, reads that frame in address order and streams it to the LPC analysis core over a valid/ready interface, with a last marker.
- Queues one pending command while busy and reports completion.

---
 rtl/lpc_frame_reader.sv | 95 +++++++++
 1 files changed

// File: rtl/lpc_frame_reader.sv
// lpc_frame_reader: streams ping-pong RAM frames to the LPC analysis core over valid/ready
module lpc_frame_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_bank,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LEN = ADDR_W'(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] base, count;
  logic in_flight, in_flight_last, pend_valid, pend_bank;
  logic [DATA_W:0] fifo [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] fifo_count;
  logic pop, launch, launch_bank, issue_last;
  assign out_valid = fifo_count != 2'd0;
  assign out_data = out_valid ? fifo[rd_ptr][DATA_W-1:0] : '0;
  assign out_last = out_valid && fifo[rd_ptr][DATA_W];
  assign pop = out_valid && out_ready;
  assign launch = state == IDLE && (pend_valid || start);
  assign launch_bank = pend_valid ? pend_bank : start_bank;
  assign issue_last = count == LAST;
  // A same-cycle pop frees a slot in time for the read issued now, giving one sample per clock
  assign mem_clken = state == READ && (fifo_count + {1'b0, in_flight} - {1'b0, pop}) < 2'd2;
  assign mem_chipselect = mem_clken;
  assign mem_address = base + count;
  assign mem_write = 1'b0;
  assign mem_byteenable = 2'b11;
  assign busy = state != IDLE || pend_valid;
  always_comb begin
    state_n = state;
    if (launch) state_n = READ;
    if (state == READ && mem_clken && issue_last) state_n = DRAIN;
    if (state == DRAIN && pop && out_last) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base <= '0;
      count <= '0;
      in_flight <= 1'b0;
      in_flight_last <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      fifo_count <= 2'd0;
      pend_valid <= 1'b0;
      pend_bank <= 1'b0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      in_flight <= mem_clken;
      in_flight_last <= mem_clken && issue_last;
      done <= state == DRAIN && pop && out_last;
      if (launch) begin
        base <= launch_bank ? LEN : '0;
        count <= '0;
      end else if (mem_clken) count <= count + ADDR_W'(1);
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};
      // A pending command launches first; a start arriving alongside it takes its slot
      if (state == IDLE && pend_valid) begin
        pend_valid <= start;
        pend_bank <= start ? start_bank : pend_bank;
      end else if (state != IDLE && start) begin
        if (pend_valid) overflow <= 1'b1;
        else begin
          pend_valid <= 1'b1;
          pend_bank <= start_bank;
        end
      end
    end
  end
  always_ff @(posedge clk) if (in_flight) fifo[wr_ptr] <= {in_flight_last, mem_readdata};
endmodule
